pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8, SHALL set the program counter and target width.
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the number of return-stack entries.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 instr_valid  input  1  SHALL indicate that the decoded instruction for the current pc is present.
REQ-006 instr_ready  output  1  SHALL indicate that the sequencer accepts an instruction this cycle.
REQ-007 op  input  2  SHALL select the flow operation: 00 sequential, 01 conditional jump, 10 call, 11 return.
REQ-008 cond_result  input  1  SHALL be the branch-condition result from the condition evaluator, sampled only for op 01.
REQ-009 target  input  PC_WIDTH  SHALL be the jump/call destination address.
REQ-010 pc  output  PC_WIDTH  SHALL be the registered address of the instruction to fetch.
REQ-011 flush  output  1  SHALL be high during the one bubble cycle after a control transfer.
REQ-012 halted  output  1  SHALL be high while in HALT.
REQ-013 stack_err  output  1  SHALL be a sticky flag for a return-stack overflow or underflow.
REQ-014 depth  output  $clog2(STACK_DEPTH+1)  SHALL give the current return-stack occupancy.

Function
REQ-015 An instruction SHALL be accepted only on a cycle with instr_valid=1 and instr_ready=1; all other cycles SHALL leave pc and the stack unchanged.
REQ-016 The state machine SHALL have the states RUN, FLUSH and HALT; instr_ready SHALL be 1 only in RUN.
REQ-017 For an accepted op 00, pc SHALL become pc+1 modulo 2^PC_WIDTH on the next edge, and the state SHALL remain RUN.
REQ-018 For an accepted op 01 with cond_result=1, pc SHALL become target and the state SHALL go to FLUSH.
REQ-019 For an accepted op 01 with cond_result=0, the behaviour SHALL be identical to op 00.
REQ-020 For an accepted op 10 with depth<STACK_DEPTH, the block SHALL push pc+1 (wrapped), set pc to target, increment depth and go to FLUSH.
REQ-021 For an accepted op 11 with depth>0, the block SHALL pop the top entry into pc, decrement depth and go to FLUSH.
REQ-022 For an accepted op 10 with depth=STACK_DEPTH, or an accepted op 11 with depth=0, the following SHALL apply:
- pc SHALL be unchanged.
- The stack SHALL be unchanged.
- stack_err SHALL be set.
- The state SHALL go to HALT.
REQ-023 FLUSH SHALL last exactly one cycle, with flush=1 and instr_ready=0, and SHALL then return to RUN unconditionally.
REQ-024 HALT SHALL be exited only by reset, with halted=1 and instr_ready=0; instr_valid SHALL be ignored in HALT.
REQ-025 The stack SHALL be LIFO: a return SHALL pop the most recently pushed, not-yet-popped address.
REQ-026 A call or return SHALL NOT depend on cond_result.
REQ-027 pc, flush, halted, stack_err and depth SHALL be registered outputs; instr_ready SHALL be decoded from the state only.
REQ-028 PC arithmetic SHALL be unsigned and SHALL wrap, so that pc=2^PC_WIDTH-1 plus 1 gives 0.

Reset
REQ-029 While rst_n=0, the outputs SHALL be: pc=0, state=RUN, flush=0, halted=0, stack_err=0, depth=0.
REQ-030 Reset assertion SHALL take effect immediately, including mid-FLUSH and in HALT; stack entry contents need not be cleared.
REQ-031 After rst_n deasserts, the first accepted instruction SHALL be the one at pc=0.

Verification
REQ-032 Sequential run: three accepted op 00 from reset -> pc 0,1,2,3 and flush stays 0.
REQ-033 Conditional jump: at pc=5, op 01, target=0x40, cond_result=1 -> next cycle pc=0x40, flush=1, instr_ready=0; the cycle after gives instr_ready=1. Repeat with cond_result=0 -> pc=6 and no flush.
REQ-034 Call/return nest: call to 0x10 from pc=2, then call to 0x20 from pc=0x10, then ret, then ret -> pc sequence 0x10, 0x20, 0x11, 0x03, and depth 1, 2, 1, 0.
REQ-035 Overflow: with STACK_DEPTH=4, perform five calls -> the fifth gives stack_err=1, halted=1, pc equal to its pre-call value and depth=4; later instr_valid has no effect.
REQ-036 Underflow and wrap: ret at depth=0 -> HALT with stack_err=1. Separately, op 00 at pc=0xFF -> pc=0x00.
REQ-037 Reset mid-operation: assert rst_n=0 during FLUSH and during HALT -> outputs match REQ-029 in the same cycle, and normal RUN resumes after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential / conditional-jump / call / return flow
// with a LIFO return stack, one-cycle bubble after transfers, sticky HALT on stack error.
module pc_sequencer #(
  parameter  int PC_WIDTH    = 8,
  parameter  int STACK_DEPTH = 4,
  localparam int DW          = $clog2(STACK_DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [1:0]          op,
  input  logic                cond_result,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                flush,
  output logic                halted,
  output logic                stack_err,
  output logic [DW-1:0]       depth
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  typedef struct packed {
    logic [1:0]          op;
    logic                cond;
    logic [PC_WIDTH-1:0] target;
  } req_t;

  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  state_t                                state, state_nxt;
  req_t                                  req;
  logic [PC_WIDTH-1:0]                   pc_nxt, pc_inc, stack_top;
  logic [DW-1:0]                         depth_nxt;
  logic                                  push, err;
  logic [STACK_DEPTH-1:0][PC_WIDTH-1:0]  stack_rd;

  assign req    = '{op: op, cond: cond_result, target: target};
  assign pc_inc = pc + PC_WIDTH'(1);

  // Entry i holds the return address pushed when occupancy was i; contents are not reset.
  for (genvar i = 0; i < STACK_DEPTH; i++) begin : g_stk
    localparam logic [DW-1:0] IDX = DW'(i);
    logic [PC_WIDTH-1:0] entry;
    always_ff @(posedge clk)
      if (push && depth == IDX) entry <= pc_inc;
    assign stack_rd[i] = entry;
  end

  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (depth == DW'(i+1)) stack_top = stack_rd[i];
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= '0;
      depth     <= '0;
      flush     <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      depth     <= depth_nxt;
      flush     <= (state_nxt == FLUSH);
      halted    <= (state_nxt == HALT);
      stack_err <= stack_err | err;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    depth_nxt = depth;
    push      = 1'b0;
    err       = 1'b0;
    case (state)
      RUN: if (instr_valid) begin
        case (req.op)
          2'b00: pc_nxt = pc_inc;
          2'b01: begin
            if (req.cond) begin
              pc_nxt    = req.target;
              state_nxt = FLUSH;
            end else begin
              pc_nxt = pc_inc;
            end
          end
          2'b10: begin
            if (depth == FULL) begin
              err       = 1'b1;
              state_nxt = HALT;
            end else begin
              push      = 1'b1;
              pc_nxt    = req.target;
              depth_nxt = depth + DW'(1);
              state_nxt = FLUSH;
            end
          end
          default: begin
            if (depth == '0) begin
              err       = 1'b1;
              state_nxt = HALT;
            end else begin
              pc_nxt    = stack_top;
              depth_nxt = depth - DW'(1);
              state_nxt = FLUSH;
            end
          end
        endcase
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = HALT;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    instr_ready = (state == RUN);
  end

endmodule
